// File: rtl/scc_pkg.sv
// rtl/scc_pkg.sv - register map, status/control bit indices and FSM state types
package scc_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_DIVL = 2'd2;
  localparam logic [1:0] ADDR_DIVH = 2'd3;

  localparam int ST_RX_AVAIL  = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_TXIE      = 4;
  localparam int ST_RXIE      = 5;

  localparam int CTL_RXIE    = 0;
  localparam int CTL_TXIE    = 1;
  localparam int CTL_CLR_OVR = 2;
  localparam int CTL_CLR_FE  = 3;
  localparam int CTL_LOOP    = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/scc_fifo.sv
// rtl/scc_fifo.sv - power-of-two FIFO; pointers carry an extra wrap bit for full/empty
module scc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q == {~rptr_q[PW-1], rptr_q[PW-2:0]});
    do_pop   = pop & ~empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    do_push  = push & (~full | do_pop);
    wptr_d   = do_push ? wptr_q + PW'(1) : wptr_q;
    rptr_d   = do_pop ? rptr_q + PW'(1) : rptr_q;
    pop_data = mem_q[rptr_q[PW-2:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PW-2:0]] <= push_data;
  end

endmodule

// File: rtl/scc_async_chan.sv
// rtl/scc_async_chan.sv - 8N1 async serial channel with register interface and RX FIFO
// Optional TX->RX loopback on control bit4 when SCC_LOOPBACK_EN is defined.
module scc_async_chan #(
  parameter int          RX_DEPTH  = 4,
  parameter logic [15:0] DIV_RESET = 16'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);
  import scc_pkg::*;

  logic [15:0] div_q, div_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bitn_q, tx_bitn_d;
  logic        tx_bit_q, tx_bit_d, tx_load;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bitn_q, rx_bitn_d;
  logic        rx_prev_q, rx_prev_d, rx_push, rx_ferr, rx_in;
  logic        rxie_q, rxie_d, txie_q, txie_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic [7:0]  rdata_q, rdata_d, status;
  logic        irq_q, irq_d;
  logic        wr_en, rd_en, rd_pop, tx_empty, loop_on;
  logic [7:0]  fifo_dout;
  logic        fifo_full, fifo_empty;

`ifdef SCC_LOOPBACK_EN
  logic loop_q, loop_d;
  assign loop_on = loop_q;
`else
  assign loop_on = 1'b0;
`endif

  assign wr_en    = cs & wr;
  assign rd_en    = cs & rd;
  assign rd_pop   = rd_en & (addr == ADDR_DATA);
  assign tx_empty = ~hold_full_q & (tx_state_q == TX_IDLE);
  assign rx_in    = loop_on ? tx_bit_q : rxd;
  assign txd      = loop_on ? 1'b1 : tx_bit_q;
  assign rdata    = rdata_q;
  assign irq      = irq_q;
  assign rx_half  = {1'b0, div_q[15:1]} + {15'd0, div_q[0]};

  scc_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_shift_q),
    .pop(rd_pop), .pop_data(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );

  always_comb begin
    tx_state_d = tx_state_q; tx_cnt_d = tx_cnt_q; tx_div_d = tx_div_q;
    tx_shift_d = tx_shift_q; tx_bitn_d = tx_bitn_q; tx_bit_d = tx_bit_q;
    hold_d = hold_q; hold_full_d = hold_full_q; tx_load = 1'b0;
    if (wr_en && addr == ADDR_DATA && !hold_full_q) begin
      hold_d = wdata;
      hold_full_d = 1'b1;
    end
    case (tx_state_q)
      TX_IDLE: tx_load = hold_full_q;
      TX_START:
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = TX_DATA; tx_cnt_d = tx_div_q; tx_bitn_d = 3'd0; tx_bit_d = tx_shift_q[0];
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      TX_DATA:
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = tx_div_q;
          if (tx_bitn_q == 3'd7) begin
            tx_state_d = TX_STOP; tx_bit_d = 1'b1;
          end else begin
            tx_bitn_d = tx_bitn_q + 3'd1; tx_shift_d = {1'b0, tx_shift_q[7:1]}; tx_bit_d = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      TX_STOP:
        if (tx_cnt_q == 16'd0) begin
          if (hold_full_q) tx_load = 1'b1;
          else begin
            tx_state_d = TX_IDLE; tx_bit_d = 1'b1;
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      default: tx_state_d = TX_IDLE;
    endcase
    // the divisor is captured per frame so a mid-frame write cannot stretch bits
    if (tx_load) begin
      tx_state_d = TX_START; tx_shift_d = hold_q; hold_full_d = 1'b0;
      tx_cnt_d = div_q; tx_div_d = div_q; tx_bitn_d = 3'd0; tx_bit_d = 1'b0;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q; rx_cnt_d = rx_cnt_q; rx_div_d = rx_div_q;
    rx_shift_d = rx_shift_q; rx_bitn_d = rx_bitn_q; rx_prev_d = rx_in;
    rx_push = 1'b0; rx_ferr = 1'b0;
    case (rx_state_q)
      RX_IDLE:
        if (rx_prev_q && !rx_in) begin
          rx_state_d = RX_START; rx_div_d = div_q;
          rx_cnt_d = (rx_half == 16'd0) ? 16'd0 : rx_half - 16'd1;
        end
      RX_START:
        if (rx_cnt_q == 16'd0) begin
          if (rx_in) rx_state_d = RX_IDLE;
          else begin
            rx_state_d = RX_DATA; rx_cnt_d = rx_div_q; rx_bitn_d = 3'd0;
          end
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      RX_DATA:
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_in, rx_shift_q[7:1]}; rx_cnt_d = rx_div_q;
          if (rx_bitn_q == 3'd7) rx_state_d = RX_STOP;
          else rx_bitn_d = rx_bitn_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      RX_STOP:
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = RX_IDLE;
          if (rx_in) rx_push = 1'b1;
          else rx_ferr = 1'b1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    div_d = div_q; rxie_d = rxie_q; txie_d = txie_q; rdata_d = rdata_q;
    overrun_d = overrun_q; frame_err_d = frame_err_q;
`ifdef SCC_LOOPBACK_EN
    loop_d = loop_q;
`endif
    status = 8'h00;
    status[ST_RX_AVAIL]  = ~fifo_empty;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_OVERRUN]   = overrun_q;
    status[ST_FRAME_ERR] = frame_err_q;
    status[ST_TXIE]      = txie_q;
    status[ST_RXIE]      = rxie_q;
    if (rd_en) begin
      case (addr)
        ADDR_DATA: rdata_d = fifo_empty ? 8'h00 : fifo_dout;
        ADDR_STAT: rdata_d = status;
        ADDR_DIVL: rdata_d = div_q[7:0];
        default:   rdata_d = div_q[15:8];
      endcase
    end
    if (wr_en) begin
      case (addr)
        ADDR_STAT: begin
          rxie_d = wdata[CTL_RXIE];
          txie_d = wdata[CTL_TXIE];
          if (wdata[CTL_CLR_OVR]) overrun_d = 1'b0;
          if (wdata[CTL_CLR_FE]) frame_err_d = 1'b0;
`ifdef SCC_LOOPBACK_EN
          loop_d = wdata[CTL_LOOP];
`endif
        end
        ADDR_DIVL: div_d[7:0] = wdata;
        ADDR_DIVH: div_d[15:8] = wdata;
        default: ;
      endcase
    end
    // a same-cycle pop makes room, so only an unrelieved full FIFO overruns
    if (rx_push && fifo_full && !rd_pop) overrun_d = 1'b1;
    if (rx_ferr) frame_err_d = 1'b1;
    irq_d = (rxie_q & ~fifo_empty) | (txie_q & ~hold_full_q) | overrun_q | frame_err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= DIV_RESET; hold_q <= 8'h00; hold_full_q <= 1'b0;
      tx_state_q <= TX_IDLE; tx_cnt_q <= 16'd0; tx_div_q <= 16'd0;
      tx_shift_q <= 8'h00; tx_bitn_q <= 3'd0; tx_bit_q <= 1'b1;
      rx_state_q <= RX_IDLE; rx_cnt_q <= 16'd0; rx_div_q <= 16'd0;
      rx_shift_q <= 8'h00; rx_bitn_q <= 3'd0; rx_prev_q <= 1'b1;
      rxie_q <= 1'b0; txie_q <= 1'b0; overrun_q <= 1'b0; frame_err_q <= 1'b0;
      rdata_q <= 8'h00; irq_q <= 1'b0;
`ifdef SCC_LOOPBACK_EN
      loop_q <= 1'b0;
`endif
    end else begin
      div_q <= div_d; hold_q <= hold_d; hold_full_q <= hold_full_d;
      tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_div_q <= tx_div_d;
      tx_shift_q <= tx_shift_d; tx_bitn_q <= tx_bitn_d; tx_bit_q <= tx_bit_d;
      rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_div_q <= rx_div_d;
      rx_shift_q <= rx_shift_d; rx_bitn_q <= rx_bitn_d; rx_prev_q <= rx_prev_d;
      rxie_q <= rxie_d; txie_q <= txie_d; overrun_q <= overrun_d; frame_err_q <= frame_err_d;
      rdata_q <= rdata_d; irq_q <= irq_d;
`ifdef SCC_LOOPBACK_EN
      loop_q <= loop_d;
`endif
    end
  end

endmodule

// File: tb/tb_scc_async_chan.sv
// tb/tb_scc_async_chan.sv - directed self-checking bench for scc_async_chan
module tb_scc_async_chan;

  logic       clk = 1'b0;
  logic       reset, cs, rd, wr, rxd;
  logic [1:0] addr;
  logic [7:0] wdata, rdata;
  logic       txd, irq;
  int         checks = 0;
  int         errors = 0;

  scc_async_chan #(.RX_DEPTH(4), .DIV_RESET(16'd15)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rxd(rxd), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    tick();
    cs = 1'b0; rd = 1'b0;
    d = rdata;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
    rxd = 1'b0;
    repeat (div + 1) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (div + 1) tick();
    end
    rxd = stop;
    repeat (div + 1) tick();
    rxd = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b required 1", txd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h required 00", rdata); end
    bus_read(2'd1, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL reset_status: got %h required 02", v); end
    bus_read(2'd2, v);
    checks++; if (v !== 8'h0F) begin errors++; $display("FAIL reset_div_lo: got %h required 0f", v); end
    bus_read(2'd3, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_div_hi: got %h required 00", v); end
  endtask

  task automatic test_tx();
    logic [7:0] v;
    logic [9:0] bits;
    logic       bad_val;
    int         n;
    bit         ok;
    bits = {1'b1, 8'hA5, 1'b0};
    bus_write(2'd2, 8'd3);
    bus_write(2'd3, 8'd0);
    bus_write(2'd0, 8'hA5);
    n = 0;
    while (txd !== 1'b0 && n < 40) begin tick(); n++; end
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL tx_start_seen: got %b required 0", txd); end
    for (int p = 0; p < 10; p++) begin
      ok = 1'b1; bad_val = 1'b0;
      for (int s = 0; s < 4; s++) begin
        if (p != 0 || s != 0) tick();
        if (txd !== bits[p] && ok) begin ok = 1'b0; bad_val = txd; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL tx_period%0d: got %b required %b", p, bad_val, bits[p]); end
    end
    tick();
    bus_read(2'd1, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL tx_empty_after: got %h required 02", v); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] bits;
    logic [7:0]  v;
    int          n, bad1, bad2, bad_idle;
    bits = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    bad1 = 0; bad2 = 0; bad_idle = 0;
    bus_write(2'd0, 8'h00);
    n = 0;
    while (txd !== 1'b0 && n < 40) begin tick(); n++; end
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL b2b_start_seen: got %b required 0", txd); end
    for (int k = 0; k < 80; k++) begin
      if (k > 0) begin
        if (k == 1) begin cs = 1'b1; wr = 1'b1; addr = 2'd0; wdata = 8'hFF; end
        if (k == 2) begin cs = 1'b1; wr = 1'b1; addr = 2'd0; wdata = 8'h81; end
        tick();
        cs = 1'b0; wr = 1'b0;
      end
      if (txd !== bits[k/4]) begin
        if (k < 40) bad1++;
        else bad2++;
      end
    end
    checks++; if (bad1 != 0) begin errors++; $display("FAIL b2b_frame1: got %0d wrong samples required 0", bad1); end
    checks++; if (bad2 != 0) begin errors++; $display("FAIL b2b_frame2: got %0d wrong samples required 0", bad2); end
    for (int k = 0; k < 12; k++) begin
      tick();
      if (txd !== 1'b1) bad_idle++;
    end
    checks++; if (bad_idle != 0) begin errors++; $display("FAIL b2b_no_third: got %0d low samples required 0", bad_idle); end
    bus_read(2'd1, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL b2b_status: got %h required 02", v); end
  endtask

  task automatic test_rx();
    logic [7:0] v;
    bus_write(2'd1, 8'h01);
    send_frame(8'h3C, 1'b1, 3);
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq_set: got %b required 1", irq); end
    bus_read(2'd1, v);
    checks++; if (v !== 8'h23) begin errors++; $display("FAIL rx_status_avail: got %h required 23", v); end
    bus_read(2'd0, v);
    checks++; if (v !== 8'h3C) begin errors++; $display("FAIL rx_data: got %h required 3c", v); end
    bus_read(2'd1, v);
    checks++; if (v !== 8'h22) begin errors++; $display("FAIL rx_status_drained: got %h required 22", v); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clear: got %b required 0", irq); end
    bus_write(2'd1, 8'h02);
    tick(); tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL txie_irq: got %b required 1", irq); end
    bus_read(2'd1, v);
    checks++; if (v !== 8'h12) begin errors++; $display("FAIL txie_status: got %h required 12", v); end
    bus_write(2'd1, 8'h00);
    tick(); tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b required 0", irq); end
  endtask

  task automatic test_overrun();
    logic [7:0] v;
    logic [7:0] frames [5];
    frames[0] = 8'h11; frames[1] = 8'h22; frames[2] = 8'h33; frames[3] = 8'h44; frames[4] = 8'h55;
    for (int f = 0; f < 5; f++) send_frame(frames[f], 1'b1, 3);
    tick();
    bus_read(2'd1, v);
    checks++; if (v !== 8'h07) begin errors++; $display("FAIL ovr_status: got %h required 07", v); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovr_irq: got %b required 1", irq); end
    for (int f = 0; f < 4; f++) begin
      bus_read(2'd0, v);
      checks++;
      if (v !== frames[f]) begin errors++; $display("FAIL ovr_read%0d: got %h required %h", f, v, frames[f]); end
    end
    bus_read(2'd0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL ovr_read_empty: got %h required 00", v); end
    bus_write(2'd1, 8'h04);
    tick(); tick();
    bus_read(2'd1, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL ovr_cleared: got %h required 02", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovr_irq_clear: got %b required 0", irq); end
  endtask

  task automatic test_frame_err();
    logic [7:0] v;
    send_frame(8'h5A, 1'b0, 3);
    tick(); tick();
    bus_read(2'd1, v);
    checks++; if (v !== 8'h0A) begin errors++; $display("FAIL fe_status: got %h required 0a", v); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL fe_irq: got %b required 1", irq); end
    bus_read(2'd0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL fe_no_push: got %h required 00", v); end
    bus_write(2'd1, 8'h08);
    bus_read(2'd1, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL fe_cleared: got %h required 02", v); end
  endtask

  task automatic test_glitch();
    logic [7:0] v;
    bus_write(2'd2, 8'd7);
    rxd = 1'b0;
    tick(); tick();
    rxd = 1'b1;
    repeat (20) tick();
    bus_read(2'd1, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL glitch_no_push: got %h required 02", v); end
    send_frame(8'h96, 1'b1, 7);
    tick();
    bus_read(2'd1, v);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL glitch_next_avail: got %h required 03", v); end
    bus_read(2'd0, v);
    checks++; if (v !== 8'h96) begin errors++; $display("FAIL glitch_next_data: got %h required 96", v); end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] v;
    int         bad;
    bus_write(2'd0, 8'h00);
    repeat (10) tick();
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL midtx_in_flight: got %b required 0", txd); end
    reset = 1'b1;
    tick();
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midtx_txd_high: got %b required 1", txd); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL midtx_rdata: got %h required 00", rdata); end
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (txd !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midtx_aborted: got %0d low samples required 0", bad); end
    bus_read(2'd1, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL midtx_status: got %h required 02", v); end
    bus_read(2'd2, v);
    checks++; if (v !== 8'h0F) begin errors++; $display("FAIL midtx_div_lo: got %h required 0f", v); end
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; rxd = 1'b1; addr = 2'd0; wdata = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scc_async_chan.md
SCC_ASYNC_CHAN -- requirements
Module: scc_async_chan

Interface
REQ-001 The block SHALL have parameter RX_DEPTH, default 4, meaning receive FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter DIV_RESET, default 16'd15, meaning baud divisor value after reset.
REQ-003 Port: clk  in  1  sole clock; every flop on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: cs  in  1  chip select; qualifies rd and wr.
REQ-006 Port: rd  in  1  read strobe, one-cycle pulse.
REQ-007 Port: wr  in  1  write strobe, one-cycle pulse.
REQ-008 Port: addr  in  2  register select: 0 data, 1 status/control, 2 divisor low, 3 divisor high.
REQ-009 Port: wdata  in  8  write data.
REQ-010 Port: rdata  out  8  registered read data.
REQ-011 Port: rxd  in  1  serial input; idle high; already synchronised upstream.
REQ-012 Port: txd  out  1  serial output; idle high.
REQ-013 Port: irq  out  1  level interrupt, active-high.

Function
REQ-014 The bit period SHALL be DIV+1 clk cycles, where DIV is the 16-bit divisor register; the frame is 8N1, LSB first.
REQ-015 A cs&wr to addr 0 SHALL load the TX holding register if it is empty; if it is full, the write SHALL be ignored.
REQ-016 The TX FSM SHALL use states IDLE, START, DATA(8 bits), STOP; it moves IDLE->START on the first bit tick while holding is full, transferring holding to the shifter and freeing holding that cycle.
REQ-017 The TX FSM SHALL chain back-to-back frames: after STOP it goes directly to START if holding is full.
REQ-018 The RX FSM SHALL use states IDLE, START, DATA, STOP; a falling rxd in IDLE starts a counter of (DIV+1)/2 cycles.
REQ-019 If rxd is high at the start-bit midpoint, the RX FSM SHALL return to IDLE (glitch reject); otherwise it samples each following bit every DIV+1 cycles.
REQ-020 On a valid stop bit (1), the received byte SHALL be pushed into the RX FIFO.
REQ-021 On stop bit 0, the byte SHALL be discarded and sticky status bit 3 (frame_err) set.
REQ-022 On a push while the FIFO is full, the byte SHALL be dropped, FIFO contents kept, and sticky status bit 2 (overrun) set.
REQ-023 A cs&rd to addr 0 SHALL pop the FIFO, with rdata the popped byte one cycle later; when empty it returns 8'h00 and nothing changes.
REQ-024 A simultaneous push and pop on a full FIFO SHALL succeed with no overrun.
REQ-025 Status read (addr 1) SHALL be {2'b0, rxie, txie, frame_err, overrun, tx_empty, rx_avail}, where tx_empty means holding empty and the FSM is in IDLE.
REQ-026 Control write (addr 1) SHALL apply bit0 rxie, bit1 txie, bit2 clear overrun, bit3 clear frame_err, bit4 (if compiled in) loopback.
REQ-027 A divisor write SHALL take effect at the next frame start; it SHALL not alter a frame in flight.
REQ-028 irq SHALL be (rxie & rx_avail) | (txie & holding empty) | overrun | frame_err, registered with 1-cycle latency.
REQ-029 The pointer width SHALL be $clog2(RX_DEPTH)+1, with wrap via the extra MSB for full/empty.

Reset
REQ-030 On reset: txd=1, rdata=0, irq=0, FIFO empty, both FSMs IDLE, status and control 0, DIV=DIV_RESET.
REQ-031 Reset mid-frame SHALL abort both frames immediately; txd is high on the next cycle.

Configuration
REQ-032 With SCC_LOOPBACK_EN defined, control bit4 SHALL route the internal TX serial stream to the RX input and hold txd high; without the macro, bit4 SHALL read 0 and have no effect.

Structure
REQ-033 Package scc_pkg SHALL hold register address constants, status/control bit indices, and the TX/RX state enums.
REQ-034 The RX FIFO SHALL be sub-module scc_fifo (parametrised width/depth, push/pop/full/empty).

Verification
REQ-035 Bench: DIV=3, write 8'hA5 -> txd low for 4 cycles, then bits 1,0,1,0,0,1,0,1 of 4 cycles each, then stop high; tx_empty=1 afterwards.
REQ-036 Bench: drive a 0x3C frame at DIV=3 -> rx_avail=1; data read returns 0x3C; status then reads 8'h01->8'h00 for the rx_avail bit.
REQ-037 Bench: 5 frames with RX_DEPTH=4 and no reads -> overrun=1; reads return frames 1..4; a control write of 8'h04 clears the overrun.
REQ-038 Bench: stop bit driven 0 -> no push, frame_err=1, irq=1.
REQ-039 Bench: 2-cycle rxd low glitch at DIV=7 -> no push, RX FSM back in IDLE.
REQ-040 Bench: reset asserted mid-TX -> txd=1 next cycle, status=8'h02.
